// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - handshake, status and interrupt bundle for sync_fifo_prog
interface sync_fifo_prog_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic [2:0]       irq_mask;
  logic [2:0]       irq_clr;
  logic [2:0]       irq_status;
  logic             interrupt;

  modport master (
    output wr_en, data_in, rd_en, irq_mask, irq_clr,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow, irq_status, interrupt
  );

  modport slave (
    input  wr_en, data_in, rd_en, irq_mask, irq_clr,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow, irq_status, interrupt
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - synchronous FIFO with programmable thresholds and sticky interrupts
module sync_fifo_prog #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [2:0]       irq_status;
  logic             rd_ok;
  logic             wr_ok;
  logic             af_next;
  logic             ovf_next;
  logic             unf_next;
  logic [2:0]       irq_set;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  always_comb begin
    rd_ok      = bus.rd_en && !empty;
    wr_ok      = bus.wr_en && (!full || rd_ok);
    count_next = count + {{(CW-1){1'b0}}, wr_ok} - {{(CW-1){1'b0}}, rd_ok};
    af_next    = (count_next >= AF_C);
    ovf_next   = bus.wr_en && !wr_ok;
    unf_next   = bus.rd_en && !rd_ok;
    irq_set    = {af_next && !almost_full, unf_next, ovf_next};
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      irq_status   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= af_next;
      almost_empty <= (count_next <= AE_C);
      overflow     <= ovf_next;
      underflow    <= unf_next;
      // Set takes priority over a same-cycle clear.
      irq_status   <= (irq_status & ~bus.irq_clr) | irq_set;
    end
  end

  assign bus.data_out     = data_out;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
  assign bus.irq_status   = irq_status;
  assign bus.interrupt    = |(irq_status & bus.irq_mask);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_unf;
  logic [2:0]       m_st;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input logic w, input logic [WIDTH-1:0] d, input logic r,
                            input logic [2:0] clr, input logic rs);
    bit rd_acc, wr_acc, af_before, af_now;
    if (rs) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_st   = '0;
    end else begin
      af_before = (q.size() >= AF);
      rd_acc    = r && (q.size() > 0);
      wr_acc    = w && ((q.size() < DEPTH) || rd_acc);
      if (rd_acc) m_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
      af_now = (q.size() >= AF);
      m_ovf  = w && !wr_acc;
      m_unf  = r && !rd_acc;
      m_st   = (m_st & ~clr) | {af_now && !af_before, m_unf, m_ovf};
    end
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic [2:0] clr, input logic rs);
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.irq_clr = clr;
    rst         = rs;
    @(posedge clk);
    model_edge(w, d, r, clr, rs);
    #1;
    check("count",        32'(bus.count),        32'(q.size()));
    check("full",         32'(bus.full),         32'(q.size() == DEPTH));
    check("empty",        32'(bus.empty),        32'(q.size() == 0));
    check("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
    check("data_out",     32'(bus.data_out),     32'(m_dout));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_unf));
    check("irq_status",   32'(bus.irq_status),   32'(m_st));
    check("interrupt",    32'(bus.interrupt),    32'(|(m_st & bus.irq_mask)));
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.data_in  = '0;
    bus.irq_clr  = '0;
    bus.irq_mask = 3'b001;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0; m_st = '0;
    @(negedge clk);

    step(1'b0, '0, 1'b0, 3'b000, 1'b1);
    // fill to full, then overflow, then drain in order
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 3'b000, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 3'b000, 1'b0);
    check("ovf_interrupt", 32'(bus.interrupt), 32'd1);
    step(1'b0, '0, 1'b0, 3'b000, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b0, '0, 1'b1, 3'b000, 1'b0);
    check("drained_last", 32'(bus.data_out), 32'h0010);
    // underflow, then clear its sticky bit
    step(1'b0, '0, 1'b1, 3'b000, 1'b0);
    step(1'b0, '0, 1'b0, 3'b010, 1'b0);
    // steady-state streaming across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 3'b000, 1'b0);
    for (int i = 8; i < 48; i++) step(1'b1, 16'(16'h0100 + i), 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 3'b000, 1'b0);
    // simultaneous read+write while empty
    step(1'b1, 16'h00AA, 1'b1, 3'b111, 1'b0);
    step(1'b0, '0, 1'b1, 3'b000, 1'b0);
    check("empty_rw_data", 32'(bus.data_out), 32'h00AA);
    // reset mid-operation with a write pending
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 3'b000, 1'b0);
    step(1'b1, 16'h0BAD, 1'b0, 3'b000, 1'b1);
    step(1'b0, '0, 1'b1, 3'b000, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      int wp, rp;
      if (c % 50 == 0) bus.irq_mask = 3'($urandom_range(0, 7));
      wp = ((c / 300) % 3 == 0) ? 75 : (((c / 300) % 3 == 1) ? 25 : 50);
      rp = 100 - wp;
      step(($urandom_range(0, 99) < wp),
           16'($urandom()),
           ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
           ($urandom_range(0, 399) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserted when count >= AF_LEVEL (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserted when count <= AE_LEVEL (1..DEPTH-1, < AF_LEVEL).
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 data_out  output  WIDTH  registered read data.
REQ-012 full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 almost_full / almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow / underflow  output  1 each  one-cycle error pulses.
REQ-016 irq_mask  input  3  interrupt enables, bit0 overflow, bit1 underflow, bit2 almost_full rise.
REQ-017 irq_clr  input  3  write-one-to-clear for irq_status bits.
REQ-018 irq_status  output  3  sticky event bits, same bit map as irq_mask.
REQ-019 interrupt  output  1  level interrupt = |(irq_status & irq_mask).

Function
REQ-020 Write accepted when wr_en and (not full, or rd_en accepted same cycle); data stored at write pointer, pointer increments modulo DEPTH.
REQ-021 Read accepted when rd_en and not empty; data_out loads entry at read pointer on that edge (1-cycle latency), pointer increments modulo DEPTH.
REQ-022 data_out SHALL hold its last value when no read is accepted.
REQ-023 Accepted read+write same cycle: count unchanged; when full both accepted; when empty only the write is accepted.
REQ-024 count, full, empty, almost_* SHALL be registered and reflect occupancy after the edge's accepted operations.
REQ-025 wr_en while full without accepted read: data dropped, memory/pointers unchanged, overflow=1 next cycle for one cycle.
REQ-026 rd_en while empty: no pointer change, data_out unchanged, underflow=1 next cycle for one cycle; also applies to rd_en+wr_en while empty.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no lost or duplicated entries.
REQ-028 irq_status[0]/[1] set on cycle overflow/underflow asserts; irq_status[2] set on cycle almost_full transitions 0->1.
REQ-029 Set SHALL win over irq_clr for the same bit in the same cycle; otherwise irq_clr bit=1 clears that bit.
REQ-030 irq_status SHALL set regardless of irq_mask; mask gates only interrupt (combinational from registered status and mask).

Reset
REQ-031 rst=1 at a clock edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, irq_status=0, data_out=0; memory contents unspecified.
REQ-032 rst SHALL override wr_en/rd_en on the same edge; reset mid-operation discards all stored data.
REQ-033 After rst deasserts, first accepted write SHALL occur on the next edge with wr_en=1.

Verification
REQ-034 Reset then 16 writes 0x0001..0x0010 -> full=1, count=16, almost_full from count 14, no overflow.
REQ-035 From full, one write 0xDEAD -> overflow pulse one cycle, irq_status[0]=1, interrupt=1 with irq_mask=3'b001; then 16 reads -> data_out 0x0001..0x0010 in order, each one cycle after rd_en, empty=1.
REQ-036 Read when empty -> underflow pulse, data_out unchanged, count=0; irq_clr=3'b010 next cycle -> irq_status[1]=0.
REQ-037 Fill 8, then 40 cycles of simultaneous rd_en+wr_en with incrementing data -> count stays 8, outputs in write order across pointer wrap.
REQ-038 Empty FIFO, wr_en+rd_en same cycle with 0x00AA -> count=1, underflow pulse, next read returns 0x00AA.
REQ-039 Fill 5, assert rst one cycle with wr_en=1 -> count=0, empty=1, irq_status=0; subsequent read -> underflow.
